// File: rtl/token_decoder.sv
// Token-ID to text decoder: walks a null-separated vocabulary SRAM per token and copies words to an output SRAM.
// Optional macro DECODER_SPACE_EN inserts a single 0x20 between consecutive words.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start
// TOK_RD    | token SRAM address presented, data arrives next cycle
// TOK_EVAL  | decide: terminator -> FINISH, else begin vocab walk
// VOC_RD    | vocab SRAM address presented, data arrives next cycle
// VOC_EVAL  | seek separators until target word, then copy its bytes
// FINISH    | write terminator, publish out_len, pulse done
module token_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err_vocab,
    output logic                  err_ovf,
    output logic [ADDR_WIDTH-1:0] out_len,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOK_RD,
        S_TOK_EVAL,
        S_VOC_RD,
        S_VOC_EVAL,
        S_FINISH
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] tok_ptr_q;
    logic [ADDR_WIDTH-1:0] voc_ptr_q;
    logic [ADDR_WIDTH-1:0] out_ptr_q;
    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] target_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_vocab_q;
    logic                  err_ovf_q;
    logic [ADDR_WIDTH-1:0] out_len_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_we_q;
`ifdef DECODER_SPACE_EN
    logic                  first_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tok_ptr_q   <= '0;
            voc_ptr_q   <= '0;
            out_ptr_q   <= '0;
            cnt_q       <= '0;
            target_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_vocab_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            out_len_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_we_q    <= 1'b0;
`ifdef DECODER_SPACE_EN
            first_q     <= 1'b0;
`endif
        end else begin
            out_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tok_ptr_q   <= '0;
                        out_ptr_q   <= '0;
                        err_vocab_q <= 1'b0;
                        err_ovf_q   <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef DECODER_SPACE_EN
                        first_q     <= 1'b1;
`endif
                        state_q     <= S_TOK_RD;
                    end
                end
                S_TOK_RD: state_q <= S_TOK_EVAL;
                S_TOK_EVAL: begin
                    if (tok_data == '0) begin
                        state_q <= S_FINISH;
                    end else begin
                        target_q  <= tok_data - 1'b1;
                        cnt_q     <= '0;
                        voc_ptr_q <= '0;
                        state_q   <= S_VOC_RD;
`ifdef DECODER_SPACE_EN
                        if (!first_q) begin
                            if (out_ptr_q == LAST) begin
                                err_ovf_q <= 1'b1;
                                state_q   <= S_FINISH;
                            end else begin
                                out_addr_q <= out_ptr_q;
                                out_data_q <= DATA_WIDTH'(8'h20);
                                out_we_q   <= 1'b1;
                                out_ptr_q  <= out_ptr_q + 1'b1;
                            end
                        end
`endif
                    end
                end
                S_VOC_RD: state_q <= S_VOC_EVAL;
                S_VOC_EVAL: begin
                    if (cnt_q < target_q) begin
                        if (voc_data == '0) cnt_q <= cnt_q + 1'b1;
                        if (voc_ptr_q == LAST) begin
                            err_vocab_q <= 1'b1;
                            state_q     <= S_FINISH;
                        end else begin
                            voc_ptr_q <= voc_ptr_q + 1'b1;
                            state_q   <= S_VOC_RD;
                        end
                    end else if (voc_data != '0 && out_ptr_q == LAST) begin
                        // last output slot is kept for the terminator
                        err_ovf_q <= 1'b1;
                        state_q   <= S_FINISH;
                    end else begin
                        if (voc_data != '0) begin
                            out_addr_q <= out_ptr_q;
                            out_data_q <= voc_data;
                            out_we_q   <= 1'b1;
                            out_ptr_q  <= out_ptr_q + 1'b1;
                        end
                        if (voc_data != '0 && voc_ptr_q != LAST) begin
                            voc_ptr_q <= voc_ptr_q + 1'b1;
                            state_q   <= S_VOC_RD;
                        end else begin
                            // word ends on a separator or at the top of the vocab
`ifdef DECODER_SPACE_EN
                            first_q <= 1'b0;
`endif
                            if (tok_ptr_q == LAST) begin
                                state_q <= S_FINISH;
                            end else begin
                                tok_ptr_q <= tok_ptr_q + 1'b1;
                                state_q   <= S_TOK_RD;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    out_addr_q <= out_ptr_q;
                    out_data_q <= '0;
                    out_we_q   <= 1'b1;
                    out_len_q  <= out_ptr_q;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_vocab = err_vocab_q;
    assign err_ovf   = err_ovf_q;
    assign out_len   = out_len_q;
    assign tok_addr  = tok_ptr_q;
    assign voc_addr  = voc_ptr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_we    = out_we_q;

endmodule

// File: tb/tb_token_decoder.sv
// Scoreboard bench for token_decoder: directed vectors push expected results, a monitor checks each done.
// Expectations follow the build: DECODER_SPACE_EN defined or not.
module tb_token_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, err_vocab, err_ovf, out_we;
    logic [3:0] out_len, tok_addr, voc_addr, out_addr;
    logic [7:0] tok_data, voc_data, out_data;

    logic [7:0] tok_mem [16];
    logic [7:0] voc_mem [16];
    logic [7:0] out_mem [16];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [31:0]      st;
        logic [31:0]      lat;
        logic [4:0]       len;
        logic             ev;
        logic             eo;
        logic [15:0][7:0] bytes;
    } exp_t;

    exp_t q[$];

    token_decoder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_vocab(err_vocab), .err_ovf(err_ovf), .out_len(out_len),
        .tok_addr(tok_addr), .tok_data(tok_data), .voc_addr(voc_addr),
        .voc_data(voc_data), .out_addr(out_addr), .out_data(out_data),
        .out_we(out_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        tok_data <= tok_mem[tok_addr];
        voc_data <= voc_mem[voc_addr];
        if (out_we) out_mem[out_addr] <= out_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int len, input bit ev, input bit eo, input int lat, input string s);
        exp_t e;
        e     = '0;
        e.len = len[4:0];
        e.ev  = ev;
        e.eo  = eo;
        e.lat = lat;
        for (int i = 0; i < s.len() && i < 16; i++) e.bytes[i] = s[i];
        return e;
    endfunction

    // '|' in the string stands for the 0x00 separator
    task automatic set_vocab(input string s);
        for (int i = 0; i < 16; i++) voc_mem[i] = (i < s.len() && s[i] != "|") ? s[i] : 8'h00;
    endtask

    task automatic clear_tok();
        for (int i = 0; i < 16; i++) tok_mem[i] = 8'h00;
    endtask

    task automatic clear_out();
        for (int i = 0; i < 16; i++) out_mem[i] = 8'hEE;
    endtask

    task automatic run(input exp_t e, input bit now);
        if (!now) @(negedge clk);
        start = 1'b1;
        e.st  = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 400 cycles");
        end
    endtask

    // monitor: capture results on done, check memory one cycle later once the terminator is written
    initial begin
        exp_t e;
        int   lat;
        logic [3:0] len;
        logic ev, eo;
        forever begin
            @(negedge clk);
            if (done) begin
                lat = cyc;
                len = out_len;
                ev  = err_vocab;
                eo  = err_ovf;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with empty scoreboard");
                    @(negedge clk);
                end else begin
                    e = q.pop_front();
                    chk("latency", lat - int'(e.st), int'(e.lat));
                    chk("out_len", len, int'(e.len));
                    chk("err_vocab", ev, e.ev);
                    chk("err_ovf", eo, e.eo);
                    @(negedge clk);
                    chk("done_one_cycle", done, 0);
                    for (int i = 0; i <= int'(e.len) && i < 16; i++)
                        chk($sformatf("out_mem[%0d]", i), out_mem[i], e.bytes[i]);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_tok();
        clear_out();
        set_vocab("");
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_tok_addr", tok_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // two words out of order
        set_vocab("hi|yo|");
        clear_tok();
        tok_mem[0] = 8'd2;
        tok_mem[1] = 8'd1;
`ifdef DECODER_SPACE_EN
        run(mk(5, 0, 0, 26, "yo hi"), 0);
`else
        run(mk(4, 0, 0, 26, "yohi"), 0);
`endif
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // empty stream, started in the done cycle of the previous run
        tok_mem[0] = 8'd0;
        run(mk(0, 0, 0, 4, ""), 1);
        wait_done();
        repeat (3) @(negedge clk);

        // token beyond the vocabulary
        clear_out();
        set_vocab("a|");
        clear_tok();
        tok_mem[0] = 8'd20;
        run(mk(0, 1, 0, 36, ""), 0);
        wait_done();
        repeat (3) @(negedge clk);

        // output overflow with a 12-byte word used twice
        clear_out();
        set_vocab("abcdefghijkl|");
        clear_tok();
        tok_mem[0] = 8'd1;
        tok_mem[1] = 8'd1;
`ifdef DECODER_SPACE_EN
        run(mk(15, 0, 1, 38, "abcdefghijkl ab"), 0);
`else
        run(mk(15, 0, 1, 40, "abcdefghijklabc"), 0);
`endif
        wait_done();
        repeat (3) @(negedge clk);

        // token SRAM without terminator
        clear_out();
        set_vocab("x|");
        for (int i = 0; i < 16; i++) tok_mem[i] = 8'd1;
`ifdef DECODER_SPACE_EN
        run(mk(15, 0, 1, 52, "x x x x x x x x"), 0);
`else
        run(mk(15, 0, 1, 96, "xxxxxxxxxxxxxxx"), 0);
`endif
        wait_done();
        repeat (3) @(negedge clk);

        // reset during a copy, then a fresh decode
        set_vocab("hi|yo|");
        clear_tok();
        tok_mem[0] = 8'd2;
        tok_mem[1] = 8'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err_vocab", err_vocab, 0);
        chk("midrst_err_ovf", err_ovf, 0);
        chk("midrst_out_len", out_len, 0);
        chk("midrst_tok_addr", tok_addr, 0);
        chk("midrst_voc_addr", voc_addr, 0);
        chk("midrst_out_addr", out_addr, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_we", out_we, 0);
        rst = 1'b0;
        clear_out();
        tok_mem[0] = 8'd1;
        tok_mem[1] = 8'd0;
        run(mk(2, 0, 0, 12, "hi"), 0);
        wait_done();
        repeat (4) @(negedge clk);

        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
